// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing.
// Define RV_FP_LS_EN to route LOAD_FP/STORE_FP through the load/store path.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] ir_opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instret,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [2:0] state_q, state_d;
    logic is_load, is_store, is_opimm, is_auipc, is_op;
    logic is_lui, is_branch, is_jalr, is_jal, is_legal;
    logic alu_hold;

`ifdef RV_FP_LS_EN
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    assign is_load  = (ir_opcode == OPC_LOAD) || (ir_opcode == OPC_LOAD_FP);
    assign is_store = (ir_opcode == OPC_STORE) || (ir_opcode == OPC_STORE_FP);
`else
    assign is_load  = (ir_opcode == OPC_LOAD);
    assign is_store = (ir_opcode == OPC_STORE);
`endif

    assign is_opimm  = (ir_opcode == OPC_OP_IMM);
    assign is_auipc  = (ir_opcode == OPC_AUIPC);
    assign is_op     = (ir_opcode == OPC_OP);
    assign is_lui    = (ir_opcode == OPC_LUI);
    assign is_branch = (ir_opcode == OPC_BRANCH);
    assign is_jalr   = (ir_opcode == OPC_JALR);
    assign is_jal    = (ir_opcode == OPC_JAL);
    assign is_legal  = is_load | is_store | is_opimm | is_auipc | is_op
                     | is_lui | is_branch | is_jalr | is_jal;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_load || is_store) state_d = S_MEM;
                else if (is_branch)      state_d = S_FETCH;
                else                     state_d = S_WB;
            end
            S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ALU selects stay at their EXEC value so the result is stable in MEM/WB
    assign alu_hold = (state_q == S_EXEC) || (state_q == S_MEM)
                   || (state_q == S_WB);

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        instret      = 1'b0;
        illegal      = 1'b0;
        if (alu_hold) begin
            if (is_opimm || is_load || is_store || is_jalr) begin
                alu_b_sel = 1'b1;
            end else if (is_auipc) begin
                alu_a_sel = 2'd1;
                alu_b_sel = 1'b1;
            end else if (is_lui) begin
                alu_a_sel = 2'd2;
                alu_b_sel = 1'b1;
            end
        end
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken ? 2'd1 : 2'd0;
                    instret = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (is_store && mem_ready) begin
                    pc_we   = 1'b1;
                    instret = 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                if (is_load)               wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                if (is_jal)       pc_src = 2'd1;
                else if (is_jalr) pc_src = 2'd2;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expectations queued per
// instruction, popped and compared on each instret pulse.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] ir_opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0] pc_src, alu_a_sel, wb_sel;
    logic       alu_b_sel, rf_we, instret, illegal;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        int         memc;
        logic [1:0] pc_src;
        logic [1:0] wb;
        logic       rf;
        logic       we;
        logic [1:0] a_sel;
        logic       b_sel;
        bit         chk_alu;
        bit         chk_b;
    } exp_t;

    exp_t sb[$];
    logic [2:0] trace[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .instret(instret), .illegal(illegal), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t expect_for(input logic [6:0] op, input int fw,
                                        input int mw, input bit tk);
        exp_t e;
        e = '{cyc: 4 + fw, memc: 0, pc_src: 2'd0, wb: 2'd0, rf: 1'b1,
              we: 1'b0, a_sel: 2'd0, b_sel: 1'b0, chk_alu: 1'b1,
              chk_b: 1'b1};
        case (op)
            7'b0000011, 7'b0000111: begin
                e.cyc = 5 + fw + mw; e.memc = mw + 1; e.wb = 2'd1;
                e.b_sel = 1'b1;
            end
            7'b0100011, 7'b0100111: begin
                e.cyc = 4 + fw + mw; e.memc = mw + 1; e.rf = 1'b0;
                e.we = 1'b1; e.b_sel = 1'b1;
            end
            7'b1100011: begin
                e.cyc = 3 + fw; e.rf = 1'b0; e.pc_src = tk ? 2'd1 : 2'd0;
                e.chk_alu = 1'b0;
            end
            7'b1101111: begin
                e.pc_src = 2'd1; e.wb = 2'd2; e.chk_b = 1'b0;
            end
            7'b1100111: begin
                e.pc_src = 2'd2; e.wb = 2'd2; e.b_sel = 1'b1;
            end
            7'b0010011: e.b_sel = 1'b1;
            7'b0010111: begin e.a_sel = 2'd1; e.b_sel = 1'b1; end
            7'b0110111: begin e.a_sel = 2'd2; e.b_sel = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction starting at a negedge in FETCH.
    task automatic run(input logic [6:0] op, input int fw, input int mw,
                       input bit tk, input bit legal);
        int cnt = 0;
        int cyc = 0;
        int memc = 0;
        bit saw_we = 0;
        bit done = 0;
        bit trapped = 0;
        exp_t e;
        if (legal) sb.push_back(expect_for(op, fw, mw, tk));
        trace.delete();
        ir_opcode = op;
        branch_taken = tk;
        for (int i = 0; i < 60; i++) begin
            if (mem_req)
                mem_ready = (cnt == ((state == 3'd1) ? fw : mw));
            else
                mem_ready = 1'b0;
            #1;
            cyc++;
            trace.push_back(state);
            if (mem_req) cnt = mem_ready ? 0 : cnt + 1;
            if (mem_req && mem_addr_sel) memc++;
            if (mem_we) saw_we = 1;
            if (state == 3'd6) begin
                trapped = 1;
                break;
            end
            if (instret) begin
                e = sb.pop_front();
                chk("cycles", cyc, e.cyc);
                chk("pc_src", pc_src, e.pc_src);
                chk("wb_sel", wb_sel, e.wb);
                chk("rf_we", rf_we, e.rf);
                chk("pc_we", pc_we, 1);
                chk("mem_we_seen", saw_we, e.we);
                if (e.memc != 0) chk("mem_cycles", memc, e.memc);
                if (e.chk_alu) chk("alu_a", alu_a_sel, e.a_sel);
                if (e.chk_alu && e.chk_b) chk("alu_b", alu_b_sel, e.b_sel);
                done = 1;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (done) break;
        end
        mem_ready = 1'b0;
        if (legal) begin
            chk("retired", done, 1);
            chk("back_to_fetch", state, 3'd1);
        end else begin
            chk("trapped", trapped, 1);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instret", instret, 0);
        chk("rst_mem_req", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_idle", state, 3'd0);
        chk("rel_no_req", mem_req, 0);
        @(negedge clk);
        #1;
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr_pc", mem_addr_sel, 0);
        @(negedge clk);
        #1;
        chk("fetch_hold", mem_req, 1);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        do_reset();
        // Bench held FETCH 2 cycles above with no ready; that is fine.
        run(7'b0010011, 0, 0, 0, 1);
        ok = (trace.size() == 4) && (trace[0] == 3'd1) && (trace[1] == 3'd2)
          && (trace[2] == 3'd3) && (trace[3] == 3'd5);
        chk("addi_trace", ok, 1);
        run(7'b0000011, 0, 3, 0, 1);
        run(7'b0100011, 1, 0, 0, 1);
        run(7'b1100011, 0, 0, 1, 1);
        run(7'b1100011, 2, 0, 0, 1);
        run(7'b1100111, 0, 0, 0, 1);
        run(7'b1101111, 0, 0, 0, 1);
        run(7'b0110111, 0, 0, 0, 1);
        run(7'b0010111, 1, 0, 0, 1);
        run(7'b0110011, 0, 0, 0, 1);
        run(7'b0000011, 2, 1, 0, 1);
`ifdef RV_FP_LS_EN
        run(7'b0100111, 0, 0, 0, 1);
        run(7'b0000111, 0, 0, 0, 1);
`endif
        run(7'b1110011, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (!illegal || mem_req || instret || state != 3'd6) begin
                chk("trap_hold", {illegal, mem_req, instret, state},
                    {1'b1, 1'b0, 1'b0, 3'd6});
                break;
            end
        end
        mem_ready = 1'b0;
        chk("trap_sticky", illegal, 1);
        do_reset();
`ifndef RV_FP_LS_EN
        run(7'b0100111, 0, 0, 0, 0);
        do_reset();
`endif
        // Asynchronous reset while FETCH waits on memory
        #2;
        chk("pre_async_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_drop_req", mem_req, 0);
        chk("async_state", state, 3'd0);
        chk("async_no_pcwe", pc_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
